// File: rtl/reg_file_pkg.sv
// Shared constants and default-configuration types for the RV32I register file.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ZERO     = 0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/reg_file_entry.sv
// One architectural register: data word plus busy-scoreboard bit.
// Write enable/data arrive already priority-resolved; busy set dominates clear.
module reg_file_entry
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              busy_set_i,
  input  logic              busy_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  always_comb begin
    data_d = we_i ? wdata_i : data_q;
    busy_d = busy_q;
    if (busy_clr_i) busy_d = 1'b0;
    // A new claimant on the same edge as the releasing write keeps ownership.
    if (busy_set_i) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired x0 and per-register busy scoreboard.
// Optional REG_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_ok,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]   reg_data [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                claim_acc;

  assign reg_data[REG_ZERO] = '0;
  assign busy[REG_ZERO]     = 1'b0;

  assign claim_ok  = (claim_addr == ADDR_W'(REG_ZERO)) || !busy[claim_addr];
  assign claim_acc = claim_en && claim_ok;
  assign busy_vec  = busy;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic              we;
    logic [DATA_W-1:0] wd;

    // Later ports overwrite earlier matches, so the highest port index wins.
    always_comb begin
      we = 1'b0;
      wd = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          we = 1'b1;
          wd = wr_data[w*DATA_W +: DATA_W];
        end
      end
    end

    reg_file_entry #(
      .DATA_W(DATA_W)
    ) u_entry (
      .clk       (clk),
      .reset_n   (reset_n),
      .we_i      (we),
      .wdata_i   (wd),
      .busy_set_i(claim_acc && (claim_addr == ADDR_W'(r))),
      .busy_clr_i(we),
      .data_o    (reg_data[r]),
      .busy_o    (busy[r])
    );
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*DATA_W +: DATA_W] = reg_data[rd_addr[p*ADDR_W +: ADDR_W]];
      rd_busy[p]                  = busy[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (reset_n && wr_en[w] && (rd_addr[p*ADDR_W +: ADDR_W] != '0) &&
            (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])) begin
          rd_data[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
          // The write releases the register unless a claim re-takes it this cycle.
          rd_busy[p] = (claim_en && (claim_addr == rd_addr[p*ADDR_W +: ADDR_W])) ?
                       busy[rd_addr[p*ADDR_W +: ADDR_W]] : 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the RV32I core. It replaces the fixed two-read, one-write bank with a configurable number of read and write ports, a hardwired-zero register 0, and a per-register busy scoreboard for multi-cycle producers such as loads and divides. It sits between decode (read ports), writeback (write ports) and issue (claim/busy).

## Interface
- DATA_W, 32, register width
- NUM_REGS, 32, register count; must be a power of two, at least 2
- ADDR_W, $clog2(NUM_REGS), register index width
- NUM_RD, 2, read ports, 1..4
- NUM_WR, 1, write ports, 1..2
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read indices; port p uses slice p
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  busy bit of each addressed register
- wr_en  in  NUM_WR  write strobe per port
- wr_addr  in  NUM_WR*ADDR_W  write index per port
- wr_data  in  NUM_WR*DATA_W  write data per port
- claim_en  in  1  issue requests ownership of claim_addr
- claim_addr  in  ADDR_W  register to mark busy
- claim_ok  out  1  combinational; 1 when claim_addr is not busy or is register 0
- busy_vec  out  NUM_REGS  full scoreboard; bit 0 is always 0

## Operation
- Register 0: writes are discarded, reads return 0, never busy, claims always succeed and have no effect.
- Write: on a rising edge with wr_en[w]=1 and wr_addr≠0, the register takes wr_data[w].
  - Same address on several ports in one cycle: highest port index wins.
- Busy set: on a rising edge with claim_en=1, claim_ok=1 and claim_addr≠0, busy[claim_addr] becomes 1.
- Busy clear: any accepted write to a register clears its busy bit on the same edge.
- Claim and write to the same non-zero register in one cycle: data is written, and the busy bit ends at 1 (the new claimant owns it).
- Claim of a busy register: claim_ok=0; nothing changes; issue must stall and retry.
- Reads are purely combinational from state (plus bypass, see Configuration).
  - rd_busy[p] = busy[rd_addr[p]].

## Timing
- Reset, asserted asynchronously:
  - all registers 0, busy_vec 0, so rd_data 0, rd_busy 0 and claim_ok 1.
  - Writes and claims are ignored while reset_n=0.
  - Reset asserted in the same cycle as a write or claim: reset wins, and the write or claim is lost.
- Write-to-read latency: 1 cycle without bypass, 0 cycles with bypass.
- Claim-to-busy latency: 1 cycle; claim_ok for a second claim in the same cycle is not required (single claim port).
- No internal pipelining; every output is valid in the same cycle as its inputs.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - When a read port's index matches an active write port's index (non-zero), rd_data returns that wr_data, highest port index first.
  - rd_busy is forced to 0 for that read port, unless claim_en targets the same register in that cycle.
  - Bypass is gated off while reset_n=0.
- Undefined: reads see only registered state and rd_busy reflects registered busy bits; the regfile adds no path from wr_data to rd_data.

## Structure
- Package reg_file_pkg:
  - DATA_W_DEF, NUM_REGS_DEF, REG_ZERO (index 0).
  - typedef reg_addr_t (logic [4:0]) and reg_data_t (logic [31:0]) for the default configuration.
- Sub-module reg_file_entry, one per register index 1..NUM_REGS-1:
  - holds the data word and busy bit.
  - has async reset, write-enable/data inputs already priority-resolved, and set/clear inputs for busy with set dominant.
- Top level holds write-port priority resolution, read multiplexing, bypass and the register 0 tie-off.

## Test plan
- Reset then read all 32 indices on both ports -> every rd_data 0, busy_vec 0, claim_ok 1.
- Write 32'hDEADBEEF to x5, read x5 next cycle -> DEADBEEF; write 32'h1234 to x0 -> x0 still reads 0 and busy_vec[0] stays 0.
- With NUM_WR=2, port0 writes x7=32'h1111 and port1 writes x7=32'h2222 in one cycle -> x7 reads 2222.
- Claim x9 -> busy_vec[9]=1 next cycle; second claim x9 -> claim_ok=0 with no state change; write x9=32'h55 -> busy_vec[9]=0 the following cycle; same-cycle claim and write of x9 -> data 55 written, busy stays 1.
- With REG_FILE_BYPASS_EN, write x3=32'hCAFE while reading x3 -> rd_data=CAFE in the same cycle; without the macro -> old value that cycle, CAFE the next.
- Assert reset_n mid-cycle with x4=32'hAA and busy[4]=1 -> rd_data 0 and busy_vec 0 immediately, before the next clock edge.
